// File: rtl/bic_tx_arbiter.sv
// bic_tx_arbiter: two-source round-robin transmit arbiter with bus-invert
// coding against the lines currently driven. The coded word, invert line and
// valid are held in registers under a valid/ready handshake. The bus is left
// static whenever no new word loads.
// Optional statistics counters: define BIC_TX_STATS_EN.
module bic_tx_arbiter #(
  parameter int WIDTH  = 8,
  parameter int STAT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [WIDTH-1:0] bus_data,
  output logic             bus_inv,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic             last_grant
`ifdef BIC_TX_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0] stat_toggles
`endif
);

  localparam int HW_W = $clog2(WIDTH) + 1;
  localparam logic [HW_W-1:0] HALF = HW_W'(WIDTH / 2);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             inv;
  } word_t;

  state_t           state;
  logic             slot_open;
  logic             sel;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [HW_W-1:0]  hd;
  word_t            nxt;

  function automatic logic [HW_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [HW_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + HW_W'(v[i]);
    return c;
  endfunction

  // Round-robin grant while the output slot is free, then code the winner
  // against the physical lines (not the previous raw word).
  always_comb begin
    slot_open  = (state == IDLE) || bus_ready;
    sel        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept     = rst_n && slot_open && (req0_valid || req1_valid);
    req0_ready = accept && !sel;
    req1_ready = accept && sel;
    sel_data   = sel ? req1_data : req0_data;
    hd         = popcnt(sel_data ^ bus_data);
    nxt.inv    = (hd > HALF);
    nxt.data   = nxt.inv ? ~sel_data : sel_data;
  end

  // IDLE/SEND control; bus lines change only when a new word is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus_data   <= '0;
      bus_inv    <= 1'b0;
      bus_valid  <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      state      <= SEND;
      bus_valid  <= 1'b1;
      bus_data   <= nxt.data;
      bus_inv    <= nxt.inv;
      last_grant <= sel;
    end else if (state == SEND && bus_ready) begin
      state      <= IDLE;
      bus_valid  <= 1'b0;
    end
  end

`ifdef BIC_TX_STATS_EN
  localparam int INC_W = HW_W + 1;
  localparam int SUM_W = STAT_W + INC_W;
  localparam logic [SUM_W-1:0] SAT = SUM_W'({STAT_W{1'b1}});

  logic [INC_W-1:0]  tog_inc;
  logic [SUM_W-1:0]  tog_sum;
  logic [STAT_W-1:0] tog_next;

  // Line transitions caused by the candidate word, saturated to counter range.
  always_comb begin
    tog_inc  = INC_W'(popcnt(nxt.data ^ bus_data)) + INC_W'(nxt.inv ^ bus_inv);
    tog_sum  = SUM_W'(stat_toggles) + SUM_W'(tog_inc);
    tog_next = (tog_sum > SAT) ? {STAT_W{1'b1}} : tog_sum[STAT_W-1:0];
  end

  // Saturating statistics; clear wins over any same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      stat_words   <= '0;
      stat_toggles <= '0;
    end else begin
      if (bus_valid && bus_ready && stat_words != {STAT_W{1'b1}})
        stat_words <= stat_words + STAT_W'(1);
      if (accept)
        stat_toggles <= tog_next;
    end
  end
`endif

endmodule

// File: tb/tb_bic_tx_arbiter.sv
// Self-checking bench for bic_tx_arbiter: directed scenarios with hand-derived
// constants plus a randomized run against a transaction-level model.
module tb_bic_tx_arbiter;
  localparam int WIDTH  = 8;
  localparam int STAT_W = 6;
  localparam int MAX    = (1 << STAT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] bus_data;
  logic             bus_inv, bus_valid, last_grant;
  logic             bus_ready = 1'b0;
  logic             stat_clr = 1'b0;
`ifdef BIC_TX_STATS_EN
  logic [STAT_W-1:0] stat_words, stat_toggles;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [WIDTH-1:0] m_data;
  logic             m_inv, m_valid, m_last;
  int               m_words, m_tog;
  logic             exp_r0, exp_r1, obs_r0, obs_r1;

  always #5 clk = ~clk;

  bic_tx_arbiter #(.WIDTH(WIDTH), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .bus_data(bus_data), .bus_inv(bus_inv), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .last_grant(last_grant)
`ifdef BIC_TX_STATS_EN
    , .stat_clr(stat_clr), .stat_words(stat_words), .stat_toggles(stat_toggles)
`endif
  );

  // One clock: drive at negedge, sample readies, advance the model, land
  // 1 time unit after the rising edge so registered outputs are settled.
  task automatic cyc(input logic v0, input logic [WIDTH-1:0] d0,
                     input logic v1, input logic [WIDTH-1:0] d1,
                     input logic br, input logic clr);
    logic             g, take;
    logic [WIDTH-1:0] w, nd;
    logic             ni;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    bus_ready = br; stat_clr = clr;
    #1;
    obs_r0 = req0_ready; obs_r1 = req1_ready;
    exp_r0 = 1'b0; exp_r1 = 1'b0;
    if (!rst_n) begin
      m_data = '0; m_inv = 1'b0; m_valid = 1'b0; m_last = 1'b1;
      m_words = 0; m_tog = 0;
    end else begin
      g    = (v0 && v1) ? !m_last : v1;
      take = (!m_valid || br) && (v0 || v1);
      if (clr) begin
        m_words = 0; m_tog = 0;
      end else if (m_valid && br && m_words < MAX) begin
        m_words++;
      end
      if (take) begin
        w = g ? d1 : d0;
        if ($countones(w ^ m_data) > WIDTH / 2) begin nd = ~w; ni = 1'b1; end
        else begin nd = w; ni = 1'b0; end
        if (!clr) begin
          m_tog = m_tog + $countones(nd ^ m_data) + ((ni != m_inv) ? 1 : 0);
          if (m_tog > MAX) m_tog = MAX;
        end
        exp_r0 = !g; exp_r1 = g;
        m_data = nd; m_inv = ni; m_valid = 1'b1; m_last = g;
      end else if (m_valid && br) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 8'hAA, 1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (obs_r0 !== 1'b0) begin
        errors++; $display("FAIL reset_ready: got %b exp 0", obs_r0);
      end
    end
    checks++;
    if ({bus_data, bus_inv, bus_valid, last_grant} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_regs: got data=%h inv=%b vld=%b lg=%b exp 00 0 0 1",
               bus_data, bus_inv, bus_valid, last_grant);
    end
    rst_n = 1'b1;
    cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0);
    checks++;
    if ({obs_r0, obs_r1} !== 2'b10) begin
      errors++; $display("FAIL first_tie: got r0r1=%b%b exp 10", obs_r0, obs_r1);
    end
    checks++;
    if ({bus_data, bus_inv, bus_valid, last_grant} !== {8'h11, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL first_load: got data=%h inv=%b vld=%b lg=%b exp 11 0 1 0",
               bus_data, bus_inv, bus_valid, last_grant);
    end
  endtask

  task automatic test_coding();
    logic [WIDTH-1:0] din  [4] = '{8'hF8, 8'h07, 8'hF7, 8'h08};
    logic [WIDTH-1:0] dexp [4] = '{8'h07, 8'h07, 8'hF7, 8'hF7};
    logic             iexp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, din[i], 1'b0, '0, 1'b1, 1'b0);
      checks++;
      if ({bus_data, bus_inv, bus_valid} !== {dexp[i], iexp[i], 1'b1}) begin
        errors++;
        $display("FAIL coding[%0d]: got data=%h inv=%b vld=%b exp %h %b 1",
                 i, bus_data, bus_inv, bus_valid, dexp[i], iexp[i]);
      end
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if ({obs_r0, obs_r1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL alternate[%0d]: got r0r1=%b%b", i, obs_r0, obs_r1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if ({obs_r0, obs_r1, bus_valid, last_grant} !== 4'b0111) begin
        errors++;
        $display("FAIL sole_src1[%0d]: got r0r1=%b%b vld=%b lg=%b exp 01 1 1",
                 i, obs_r0, obs_r1, bus_valid, last_grant);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cyc(1'b1, 8'h3C, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h55, 1'b1, 8'hC3, 1'b0, 1'b0);
      checks++;
      if ({obs_r0, obs_r1, bus_data, bus_inv, bus_valid} !== {2'b00, 8'h3C, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL hold[%0d]: got r0r1=%b%b data=%h inv=%b vld=%b exp 00 3c 0 1",
                 i, obs_r0, obs_r1, bus_data, bus_inv, bus_valid);
      end
    end
    cyc(1'b0, '0, 1'b1, 8'hC3, 1'b1, 1'b0);
    checks++;
    if ({obs_r1, bus_data, bus_inv, bus_valid} !== {1'b1, 8'h3C, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL release_load: got r1=%b data=%h inv=%b vld=%b exp 1 3c 1 1",
               obs_r1, bus_data, bus_inv, bus_valid);
    end
  endtask

  task automatic test_idle();
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'($urandom), 1'b0, 8'($urandom), 1'($urandom), 1'b0);
      checks++;
      if ({bus_data, bus_inv, bus_valid} !== {8'h3C, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL idle[%0d]: got data=%h inv=%b vld=%b exp 3c 1 0",
                 i, bus_data, bus_inv, bus_valid);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      cyc($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 6, 8'($urandom),
          $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
      checks++;
      if ({obs_r0, obs_r1, bus_data, bus_inv, bus_valid, last_grant} !==
          {exp_r0, exp_r1, m_data, m_inv, m_valid, m_last}) begin
        errors++;
        $display("FAIL random[%0d]: got r=%b%b d=%h i=%b v=%b lg=%b exp r=%b%b d=%h i=%b v=%b lg=%b",
                 i, obs_r0, obs_r1, bus_data, bus_inv, bus_valid, last_grant,
                 exp_r0, exp_r1, m_data, m_inv, m_valid, m_last);
      end
`ifdef BIC_TX_STATS_EN
      checks++;
      if (int'(stat_words) != m_words || int'(stat_toggles) != m_tog) begin
        errors++;
        $display("FAIL random_stats[%0d]: got w=%0d t=%0d exp w=%0d t=%0d",
                 i, stat_words, stat_toggles, m_words, m_tog);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

`ifdef BIC_TX_STATS_EN
  task automatic test_stats();
    do_reset();
    cyc(1'b1, 8'hF8, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 8'h07, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (stat_words !== 6'd2 || stat_toggles !== 6'd5) begin
      errors++;
      $display("FAIL stats_seq: got w=%0d t=%0d exp w=2 t=5", stat_words, stat_toggles);
    end
    cyc(1'b1, 8'h55, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (stat_words !== 6'd0 || stat_toggles !== 6'd0) begin
      errors++;
      $display("FAIL stats_clr: got w=%0d t=%0d exp 0 0", stat_words, stat_toggles);
    end
    for (int i = 0; i < 90; i++)
      cyc(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b1, 1'b0);
    checks++;
    if (stat_words !== 6'd63 || int'(stat_toggles) != m_tog) begin
      errors++;
      $display("FAIL stats_sat: got w=%0d t=%0d exp w=63 t=%0d",
               stat_words, stat_toggles, m_tog);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_coding();
    test_arbitration();
    test_backpressure();
    test_idle();
    test_random();
`ifdef BIC_TX_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
